// File: rtl/td4_exec_unit.sv
// td4_exec_unit: execute/write-back stage of the 4-bit minicpu.
// The stage decodes the instruction at pc and drives the external 4-bit
// adder. On the same rising edge it writes the adder result back into the
// one destination selected by the opcode.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en             retire enable; low holds all architectural state
//   instr[7:0]     instruction at pc: [7:4] opcode, [3:0] immediate
//   in_port[3:0]   external input port
//   alu_ain/bin    combinational ALU operands (bin is always the immediate)
//   alu_out, alu_c ALU sum and carry-out
//   pc             program counter
//   out_port       output port register
//   reg_a, reg_b   general registers (observe only)
//   carry          carry flag
module td4_exec_unit #(
  parameter int unsigned            WIDTH    = 4,
  parameter logic [WIDTH-1:0]       RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         instr,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   alu_ain,
  output logic [WIDTH-1:0]   alu_bin,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_c,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b,
  output logic               carry
);

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD_A = 4'b0000;
  localparam logic [OPW-1:0] OP_MOV_AB = 4'b0001;
  localparam logic [OPW-1:0] OP_IN_A  = 4'b0010;
  localparam logic [OPW-1:0] OP_MOV_A = 4'b0011;
  localparam logic [OPW-1:0] OP_MOV_BA = 4'b0100;
  localparam logic [OPW-1:0] OP_ADD_B = 4'b0101;
  localparam logic [OPW-1:0] OP_IN_B  = 4'b0110;
  localparam logic [OPW-1:0] OP_MOV_B = 4'b0111;
  localparam logic [OPW-1:0] OP_OUT_B = 4'b1001;
  localparam logic [OPW-1:0] OP_OUT_I = 4'b1011;
  localparam logic [OPW-1:0] OP_JNC   = 4'b1110;
  localparam logic [OPW-1:0] OP_JMP   = 4'b1111;

  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d, pc_q, pc_d;
  logic             carry_q, carry_d;
  logic             wr_a, wr_b, wr_out, jump, defined_op;

  assign opcode  = instr[7:4];
  assign alu_bin = WIDTH'(instr[3:0]);

  // Decode: operand A source and the single write-back destination
  always_comb begin
    alu_ain    = '0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    wr_out     = 1'b0;
    jump       = 1'b0;
    defined_op = 1'b1;
    case (opcode)
      OP_ADD_A:  begin alu_ain = a_q;     wr_a   = 1'b1; end
      OP_MOV_AB: begin alu_ain = b_q;     wr_a   = 1'b1; end
      OP_IN_A:   begin alu_ain = in_port; wr_a   = 1'b1; end
      OP_MOV_A:  begin                    wr_a   = 1'b1; end
      OP_MOV_BA: begin alu_ain = a_q;     wr_b   = 1'b1; end
      OP_ADD_B:  begin alu_ain = b_q;     wr_b   = 1'b1; end
      OP_IN_B:   begin alu_ain = in_port; wr_b   = 1'b1; end
      OP_MOV_B:  begin                    wr_b   = 1'b1; end
      OP_OUT_B:  begin alu_ain = b_q;     wr_out = 1'b1; end
      OP_OUT_I:  begin                    wr_out = 1'b1; end
      OP_JMP:    begin                    jump   = 1'b1; end
      // JNC looks at the flag as it was before this edge
      OP_JNC:    begin                    jump   = ~carry_q; end
      default:   begin                    defined_op = 1'b0; end
    endcase
  end

  // Next-state values; registers that are not the destination hold
  always_comb begin
    a_d     = wr_a   ? alu_out : a_q;
    b_d     = wr_b   ? alu_out : b_q;
    out_d   = wr_out ? alu_out : out_q;
    pc_d    = jump   ? alu_out : pc_q + WIDTH'(1);
    carry_d = defined_op ? alu_c : carry_q;
  end

  // Architectural state; reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign pc       = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_td4_exec_unit.sv
module tb_td4_exec_unit;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] instr;
  logic [3:0] in_port, alu_ain, alu_bin, alu_out, pc, out_port, reg_a, reg_b;
  logic       alu_c, carry;
  logic [4:0] sum;

  int checks   = 0;
  int failures = 0;

  // Reference 4-bit adder sitting on the ALU side of the interface
  assign sum     = {1'b0, alu_ain} + {1'b0, alu_bin};
  assign alu_out = sum[3:0];
  assign alu_c   = sum[4];

  always #5 clk = ~clk;

  td4_exec_unit #(.WIDTH(4), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr), .in_port(in_port),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_out(alu_out), .alu_c(alu_c),
    .pc(pc), .out_port(out_port), .reg_a(reg_a), .reg_b(reg_b), .carry(carry)
  );

  // Snapshot order: {pc, reg_a, reg_b, out_port, carry}
  function automatic logic [16:0] snap();
    return {pc, reg_a, reg_b, out_port, carry};
  endfunction

  task automatic step(input logic [7:0] ins);
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_port = 4'd0;
    step(8'h0F);
    rst = 1'b0;
    checks++;
    if (snap() !== {4'd0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL reset got=%h exp=%h", snap(), 17'h0);
    end
  endtask

  task automatic test_mov_add();
    step(8'h35);
    checks++;
    if (snap() !== {4'd1, 4'd5, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL mov_a_im got=%h exp=%h", snap(), {4'd1, 4'd5, 4'd0, 4'd0, 1'b0});
    end
    instr = 8'h03;
    #1;
    checks++;
    if ({alu_ain, alu_bin} !== {4'd5, 4'd3}) begin
      failures++; $display("FAIL add_operands got=%h exp=%h", {alu_ain, alu_bin}, 8'h53);
    end
    step(8'h03);
    checks++;
    if (snap() !== {4'd2, 4'd8, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL add_a got=%h exp=%h", snap(), {4'd2, 4'd8, 4'd0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_overflow_jnc();
    step(8'h3F);
    step(8'h01);
    checks++;
    if (snap() !== {4'd4, 4'd0, 4'd0, 4'd0, 1'b1}) begin
      failures++; $display("FAIL overflow got=%h exp=%h", snap(), {4'd4, 4'd0, 4'd0, 4'd0, 1'b1});
    end
    step(8'hE7);
    checks++;
    if (snap() !== {4'd5, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL jnc_not_taken got=%h exp=%h", snap(), {4'd5, 4'd0, 4'd0, 4'd0, 1'b0});
    end
    step(8'hE7);
    checks++;
    if (snap() !== {4'd7, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL jnc_taken got=%h exp=%h", snap(), {4'd7, 4'd0, 4'd0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_moves_io();
    in_port = 4'd9;
    step(8'h60);
    checks++;
    if (snap() !== {4'd8, 4'd0, 4'd9, 4'd0, 1'b0}) begin
      failures++; $display("FAIL in_b got=%h exp=%h", snap(), {4'd8, 4'd0, 4'd9, 4'd0, 1'b0});
    end
    step(8'h10);
    checks++;
    if (snap() !== {4'd9, 4'd9, 4'd9, 4'd0, 1'b0}) begin
      failures++; $display("FAIL mov_a_b got=%h exp=%h", snap(), {4'd9, 4'd9, 4'd9, 4'd0, 1'b0});
    end
    step(8'h90);
    checks++;
    if (snap() !== {4'd10, 4'd9, 4'd9, 4'd9, 1'b0}) begin
      failures++; $display("FAIL out_b got=%h exp=%h", snap(), {4'd10, 4'd9, 4'd9, 4'd9, 1'b0});
    end
    step(8'hBC);
    checks++;
    if (snap() !== {4'd11, 4'd9, 4'd9, 4'd12, 1'b0}) begin
      failures++; $display("FAIL out_im got=%h exp=%h", snap(), {4'd11, 4'd9, 4'd9, 4'd12, 1'b0});
    end
    step(8'h52);
    checks++;
    if (snap() !== {4'd12, 4'd9, 4'd11, 4'd12, 1'b0}) begin
      failures++; $display("FAIL add_b got=%h exp=%h", snap(), {4'd12, 4'd9, 4'd11, 4'd12, 1'b0});
    end
    step(8'h40);
    checks++;
    if (snap() !== {4'd13, 4'd9, 4'd9, 4'd12, 1'b0}) begin
      failures++; $display("FAIL mov_b_a got=%h exp=%h", snap(), {4'd13, 4'd9, 4'd9, 4'd12, 1'b0});
    end
    step(8'h71);
    checks++;
    if (snap() !== {4'd14, 4'd9, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL mov_b_im got=%h exp=%h", snap(), {4'd14, 4'd9, 4'd1, 4'd12, 1'b0});
    end
    in_port = 4'd6;
    step(8'h20);
    checks++;
    if (snap() !== {4'd15, 4'd6, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL in_a got=%h exp=%h", snap(), {4'd15, 4'd6, 4'd1, 4'd12, 1'b0});
    end
  endtask

  task automatic test_pc_wrap_jmp();
    step(8'h80);
    checks++;
    if (snap() !== {4'd0, 4'd6, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL pc_wrap got=%h exp=%h", snap(), {4'd0, 4'd6, 4'd1, 4'd12, 1'b0});
    end
    step(8'hF3);
    checks++;
    if (snap() !== {4'd3, 4'd6, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL jmp got=%h exp=%h", snap(), {4'd3, 4'd6, 4'd1, 4'd12, 1'b0});
    end
    step(8'h3F);
    step(8'h01);
    step(8'h80);
    checks++;
    if (snap() !== {4'd6, 4'd0, 4'd1, 4'd12, 1'b1}) begin
      failures++; $display("FAIL nop_carry_hold got=%h exp=%h", snap(), {4'd6, 4'd0, 4'd1, 4'd12, 1'b1});
    end
    step(8'hFF);
    checks++;
    if (snap() !== {4'd15, 4'd0, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL jmp_15_clears_c got=%h exp=%h", snap(), {4'd15, 4'd0, 4'd1, 4'd12, 1'b0});
    end
    step(8'h80);
    checks++;
    if (pc !== 4'd0) begin
      failures++; $display("FAIL pc_wrap2 got=%h exp=%h", pc, 4'd0);
    end
  endtask

  task automatic test_enable_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'h0F);
      checks++;
      if (snap() !== {4'd0, 4'd0, 4'd1, 4'd12, 1'b0}) begin
        failures++; $display("FAIL en_hold%0d got=%h exp=%h", i, snap(), {4'd0, 4'd0, 4'd1, 4'd12, 1'b0});
      end
    end
    checks++;
    if ({alu_ain, alu_bin} !== {4'd0, 4'd15}) begin
      failures++; $display("FAIL en_operands got=%h exp=%h", {alu_ain, alu_bin}, 8'h0F);
    end
    en = 1'b1;
    step(8'h0F);
    checks++;
    if (snap() !== {4'd1, 4'd15, 4'd1, 4'd12, 1'b0}) begin
      failures++; $display("FAIL en_resume got=%h exp=%h", snap(), {4'd1, 4'd15, 4'd1, 4'd12, 1'b0});
    end
    rst = 1'b1;
    step(8'hFA);
    rst = 1'b0;
    checks++;
    if (snap() !== {4'd0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL rst_mid got=%h exp=%h", snap(), 17'h0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; instr = 8'h00; in_port = 4'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_mov_add();
    test_overflow_jnc();
    test_moves_io();
    test_pc_wrap_jmp();
    test_enable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
